// File: rtl/fetch_unit.sv
// IF stage: PC register, IF/ID pipeline register and redirect (jr > jump > branch) with squash of the wrong-path fetch.
// Redirect is combinational and takes effect on the next edge; stall freezes PC, IF/ID and fetch_count.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        redirect,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        take;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_off = {{14{if_id_instr_q[15]}}, if_id_instr_q[15:0], 2'b00};
    take       = if_id_valid_q & (jr | jump | branch);
    redirect   = take & ~stall;

    target = if_id_pc4_q + branch_off;
    if (jr) begin
      target = jr_target;
    end else if (jump) begin
      target = {if_id_pc4_q[31:28], if_id_instr_q[25:0], 2'b00};
    end
  end

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;

    if (!stall) begin
      if (redirect) begin
        // The sequential fetch is on the wrong path: keep its address but mark it a bubble.
        pc_d          = target;
        if_id_instr_d = 32'd0;
        if_id_pc_d    = pc_q;
        if_id_pc4_d   = pc_plus4;
        if_id_valid_d = 1'b0;
      end else begin
        pc_d          = pc_plus4;
        if_id_instr_d = imem_rdata;
        if_id_pc_d    = pc_q;
        if_id_pc4_d   = pc_plus4;
        if_id_valid_d = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= 32'd0;
      if_id_pc_q    <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, which is the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port stall, input, 1 bit: when high, the PC and the IF/ID register hold.
REQ-005 The block SHALL have port branch, input, 1 bit: branch-taken decision for the instruction currently in IF/ID.
REQ-006 The block SHALL have port jump, input, 1 bit: J/JAL decoded for the instruction in IF/ID.
REQ-007 The block SHALL have port jr, input, 1 bit: JR/JALR decoded for the instruction in IF/ID.
REQ-008 The block SHALL have port jr_target, input, 32 bits: the register value used as the JR/JALR target.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: instruction memory address, combinationally equal to pc.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: instruction word, combinational read at imem_addr.
REQ-011 The block SHALL have port if_id_instr, output, 32 bits: the registered instruction.
REQ-012 The block SHALL have port if_id_pc, output, 32 bits: the registered PC of if_id_instr.
REQ-013 The block SHALL have port if_id_pc4, output, 32 bits: the registered if_id_pc + 4.
REQ-014 The block SHALL have port if_id_valid, output, 1 bit: high when IF/ID holds a real instruction.
REQ-015 The block SHALL have port redirect, output, 1 bit: combinational; high when a redirect is taken this cycle.
REQ-016 The block SHALL have port fetch_count, output, 32 bits: count of valid instructions loaded into IF/ID.

Function
REQ-017 The block SHALL form take = if_id_valid & (jr | jump | branch), and SHALL drive redirect = take & ~stall.
REQ-018 The block SHALL select the target with priority jr > jump > branch.
- jr: jr_target.
- jump: {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- branch: if_id_pc4 + (sign-extend(if_id_instr[15:0]) << 2), modulo 2^32 with wrap-around and no overflow flag.
REQ-019 Branch delay slots SHALL NOT exist: on redirect, the sequentially fetched instruction is squashed.
REQ-020 Each clock edge SHALL apply exactly one case, in priority order rst > stall > redirect > normal.
- rst: reset values per REQ-024.
- stall: pc, IF/ID and fetch_count all hold; redirect is not taken.
- redirect: pc <= target; IF/ID loaded with instr 0, valid 0, pc/pc4 of the squashed fetch; fetch_count holds.
- normal: pc <= pc + 4; IF/ID <= {imem_rdata, pc, pc+4}, valid 1; fetch_count increments.
REQ-021 Because IF/ID holds during stall, a redirect input asserted under stall SHALL be re-evaluated after stall drops; a redirect SHALL NOT be lost or duplicated.
REQ-022 PC increment SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000, and fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-023 Target addresses SHALL be used unaligned as given; alignment checking is outside this block.

Reset
REQ-024 On a clock edge with rst high, the block SHALL set pc = RESET_PC, if_id_instr = 0, if_id_pc = 0, if_id_pc4 = 0, if_id_valid = 0, and fetch_count = 0, regardless of stall or redirect.
REQ-025 During the first cycle after reset, redirect SHALL be 0 (if_id_valid = 0) and imem_addr SHALL equal RESET_PC.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.

Verification
REQ-027 The bench SHALL cover reset then 3 cycles of no stall/branch: imem_addr 0x3000 -> 0x3004 -> 0x3008; if_id_pc 0x3000, 0x3004; fetch_count = 3.
REQ-028 The bench SHALL cover a taken branch with if_id_pc = 0x3008 and imm = 16'hFFFE: next pc = 0x3004; if_id_valid = 0 for one cycle; fetch_count unchanged that cycle.
REQ-029 The bench SHALL cover jump and branch both asserted, with jr_target = 0x4000 and jr also high: next pc = 0x4000 (jr wins); with only jump high and instr_index = 26'h100, next pc = {pc4[31:28], 0x400}.
REQ-030 The bench SHALL cover stall high for 2 cycles with branch high: pc, IF/ID and fetch_count constant and redirect = 0; on the cycle stall drops, redirect = 1 and the target is loaded.
REQ-031 The bench SHALL cover pc = 0xFFFF_FFFC under normal fetch: next pc = 0x0000_0000 and if_id_pc4 = 0x0000_0000.
REQ-032 The bench SHALL cover rst asserted while stall = 1 and branch = 1: the next edge gives pc = RESET_PC, if_id_valid = 0, and fetch_count = 0.
